view_cmd_sched: RTL and testbench

VIEW_CMD_SCHED -- requirements
Module: view_cmd_sched

---
 rtl/view_cmd_sched_pkg.sv | 59 +++++
 rtl/tok_fifo.sv | 64 ++++++
 rtl/view_cmd_sched.sv | 148 ++++++++++++++
 tb/tb_view_cmd_sched.sv | 240 ++++++++++++++++++++++++
 4 files changed

// File: rtl/view_cmd_sched_pkg.sv
// Shared definitions for the view command scheduler: token codes, cmd bit
// positions, FSM state and source ids, plus token decode helpers.
// Pure declarations, no latency; no flow control of its own.
package view_cmd_sched_pkg;

  // Token codes
  localparam logic [7:0] TOK_NONE     = 8'd0;
  localparam logic [7:0] TOK_CHAR_MIN = 8'd1;
  localparam logic [7:0] TOK_CHAR_MAX = 8'd63;
  localparam logic [7:0] TOK_BKSP     = 8'd65;
  localparam logic [7:0] TOK_BRK      = 8'd66;
  localparam logic [7:0] TOK_PGUP     = 8'd67;
  localparam logic [7:0] TOK_PGDN     = 8'd68;

  // cmd bit indices
  localparam int CMD_BUSY = 0;
  localparam int CMD_PGUP = 1;
  localparam int CMD_PGDN = 2;
  localparam int CMD_BKSP = 3;
  localparam int CMD_BRK  = 4;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_GAP   = 2'd2
  } state_t;

  typedef enum logic {
    SRC_KB = 1'b0,
    SRC_EV = 1'b1
  } src_t;

  function automatic logic tok_is_char(input logic [7:0] tok);
    return (tok >= TOK_CHAR_MIN) && (tok <= TOK_CHAR_MAX);
  endfunction

  function automatic logic tok_is_valid(input logic [7:0] tok);
    return tok_is_char(tok) || ((tok >= TOK_BKSP) && (tok <= TOK_PGDN));
  endfunction

  function automatic logic [5:0] tok_data(input logic [7:0] tok);
    return tok_is_char(tok) ? tok[5:0] : 6'd0;
  endfunction

  // Strobe pattern for a control token; busy bit is never set here.
  function automatic logic [7:0] tok_cmd(input logic [7:0] tok);
    logic [7:0] c;
    c = 8'd0;
    case (tok)
      TOK_PGUP: c[CMD_PGUP] = 1'b1;
      TOK_PGDN: c[CMD_PGDN] = 1'b1;
      TOK_BKSP: c[CMD_BKSP] = 1'b1;
      TOK_BRK:  c[CMD_BRK]  = 1'b1;
      default:  c = 8'd0;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/tok_fifo.sv
// Token FIFO, 8-bit wide, DEPTH entries (power of two), registered full/empty.
// Latency: a push at edge t is visible at head/empty after edge t.
// Backpressure: push_ready = not full, registered, so it reflects occupancy
//   before any same-cycle pop; ready is low while in reset.
// Ports: clk_50mhz, reset (sync active-low), push_valid/push_ready/push_tok,
//   pop (ignored when empty), head (current oldest token), empty.
module tok_fifo #(
  parameter int DEPTH = 4
) (
  input  logic       clk_50mhz,
  input  logic       reset,
  input  logic       push_valid,
  output logic       push_ready,
  input  logic [7:0] push_tok,
  input  logic       pop,
  output logic [7:0] head,
  output logic       empty
);
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [AW:0] DEPTH_CNT = (AW + 1)'(DEPTH);

  logic [7:0]    mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]   count;
  logic [AW:0]   count_n;
  logic          do_push;
  logic          do_pop;

  assign do_push = push_valid && push_ready;
  assign do_pop  = pop && !empty;
  assign head    = mem[rd_ptr];

  always_comb begin
    count_n = count;
    case ({do_push, do_pop})
      2'b10:   count_n = count + 1'b1;
      2'b01:   count_n = count - 1'b1;
      default: count_n = count;
    endcase
  end

  always_ff @(posedge clk_50mhz) begin
    if (!reset) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count      <= '0;
      empty      <= 1'b1;
      push_ready <= 1'b0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= push_tok;
        wr_ptr      <= wr_ptr + 1'b1;
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      count      <= count_n;
      empty      <= (count_n == '0);
      push_ready <= (count_n != DEPTH_CNT);
    end
  end

endmodule

// File: rtl/view_cmd_sched.sv
// Merges keyboard and evaluator token streams into timed view commands.
// Latency: token accepted at cycle t drives cmd/data from t+2 when idle.
// Backpressure: per-source FIFO; x_ready drops when that FIFO is full.
// Ports: clk_50mhz, reset (sync active-low); kb_/ev_ valid/ready/tok streams;
//   ev_active level; cmd[4:0] strobes+busy, data character, dropped pulse.
module view_cmd_sched
  import view_cmd_sched_pkg::*;
#(
  parameter int SLOT_CYCLES = 2,
  parameter int GAP_CYCLES  = 2,
  parameter int FIFO_DEPTH  = 4
) (
  input  logic       clk_50mhz,
  input  logic       reset,
  input  logic       kb_valid,
  output logic       kb_ready,
  input  logic [7:0] kb_tok,
  input  logic       ev_valid,
  output logic       ev_ready,
  input  logic [7:0] ev_tok,
  input  logic       ev_active,
  output logic [7:0] cmd,
  output logic [5:0] data,
  output logic       dropped
);
  localparam int CNT_MAX = (SLOT_CYCLES > GAP_CYCLES) ? SLOT_CYCLES : GAP_CYCLES;
  localparam int CW      = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
  localparam logic [CW-1:0] SLOT_LOAD = CW'(SLOT_CYCLES - 1);
  localparam logic [CW-1:0] GAP_LOAD  = (GAP_CYCLES > 0) ? CW'(GAP_CYCLES - 1) : '0;

  logic [7:0]    kb_head;
  logic [7:0]    ev_head;
  logic          kb_empty;
  logic          ev_empty;
  logic          kb_pop;
  logic          ev_pop;
  logic          kb_elig;
  logic          ev_elig;
  logic          any_elig;
  src_t          grant;
  logic [7:0]    win_tok;

  state_t        state;
  logic [CW-1:0] cnt;
  src_t          last_src;
  src_t          cur_src;
  logic [7:0]    cmd_q;
  logic [5:0]    data_q;
  logic          busy_q;

  tok_fifo #(.DEPTH(FIFO_DEPTH)) u_kb_fifo (
    .clk_50mhz  (clk_50mhz),
    .reset      (reset),
    .push_valid (kb_valid),
    .push_ready (kb_ready),
    .push_tok   (kb_tok),
    .pop        (kb_pop),
    .head       (kb_head),
    .empty      (kb_empty)
  );

  tok_fifo #(.DEPTH(FIFO_DEPTH)) u_ev_fifo (
    .clk_50mhz  (clk_50mhz),
    .reset      (reset),
    .push_valid (ev_valid),
    .push_ready (ev_ready),
    .push_tok   (ev_tok),
    .pop        (ev_pop),
    .head       (ev_head),
    .empty      (ev_empty)
  );

  // While the evaluator runs only paging may pass from the keyboard; any other
  // head token stalls the whole keyboard queue so order is never changed.
  always_comb begin
    ev_elig  = !ev_empty;
    kb_elig  = !kb_empty && (!ev_active || (kb_head == TOK_PGUP) || (kb_head == TOK_PGDN));
    any_elig = ev_elig || kb_elig;
    grant    = SRC_KB;
    if (ev_elig && kb_elig) begin
      grant = (last_src == SRC_EV) ? SRC_KB : SRC_EV;
    end else if (ev_elig) begin
      grant = SRC_EV;
    end
    win_tok = (grant == SRC_EV) ? ev_head : kb_head;
    kb_pop  = (state == ST_IDLE) && any_elig && (grant == SRC_KB);
    ev_pop  = (state == ST_IDLE) && any_elig && (grant == SRC_EV);
  end

  always_ff @(posedge clk_50mhz) begin
    if (!reset) begin
      state    <= ST_IDLE;
      cnt      <= '0;
      last_src <= SRC_KB;  // evaluator wins the first tie
      cur_src  <= SRC_KB;
      cmd_q    <= 8'd0;
      data_q   <= 6'd0;
      dropped  <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      dropped <= 1'b0;
      // Busy tracks evaluator work only, independent of slot timing.
      busy_q  <= ev_active || !ev_empty || ((state == ST_ISSUE) && (cur_src == SRC_EV));
      case (state)
        ST_IDLE: begin
          if (any_elig) begin
            last_src <= grant;
            if (tok_is_valid(win_tok)) begin
              cur_src <= grant;
              cmd_q   <= tok_cmd(win_tok);
              data_q  <= tok_data(win_tok);
              cnt     <= SLOT_LOAD;
              state   <= ST_ISSUE;
            end else begin
              dropped <= 1'b1;
            end
          end
        end
        ST_ISSUE: begin
          if (cnt == '0) begin
            cmd_q  <= 8'd0;
            data_q <= 6'd0;
            if (GAP_CYCLES > 0) begin
              cnt   <= GAP_LOAD;
              state <= ST_GAP;
            end else begin
              state <= ST_IDLE;
            end
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        ST_GAP: begin
          if (cnt == '0) begin
            state <= ST_IDLE;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign cmd  = cmd_q | {7'd0, busy_q};
  assign data = data_q;

endmodule

// File: tb/tb_view_cmd_sched.sv
`timescale 1ns/1ps
module tb_view_cmd_sched;
  logic       clk_50mhz = 1'b0;
  logic       reset;
  logic       kb_valid;
  logic       kb_ready;
  logic [7:0] kb_tok;
  logic       ev_valid;
  logic       ev_ready;
  logic [7:0] ev_tok;
  logic       ev_active;
  logic [7:0] cmd;
  logic [5:0] data;
  logic       dropped;

  int n_cmp = 0;
  int n_err = 0;
  int exp_c1 [5] = '{0, 5, 5, 0, 0};

  view_cmd_sched #(.SLOT_CYCLES(2), .GAP_CYCLES(2), .FIFO_DEPTH(4)) dut (
    .clk_50mhz (clk_50mhz),
    .reset     (reset),
    .kb_valid  (kb_valid),
    .kb_ready  (kb_ready),
    .kb_tok    (kb_tok),
    .ev_valid  (ev_valid),
    .ev_ready  (ev_ready),
    .ev_tok    (ev_tok),
    .ev_active (ev_active),
    .cmd       (cmd),
    .data      (data),
    .dropped   (dropped)
  );

  always #10 clk_50mhz = ~clk_50mhz;

  task automatic tick();
    @(posedge clk_50mhz);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic slot_on();
    return (data != 6'd0) || (cmd[4:1] != 4'd0);
  endfunction

  // Waits for a slot, checks it holds for two cycles, then checks the gap.
  task automatic expect_issue(input string tag, input logic [7:0] exp_cmd, input logic [5:0] exp_data);
    int w = 0;
    while (!slot_on() && w < 40) begin
      tick();
      w++;
    end
    chk({tag, "_seen"}, 32'(slot_on()), 32'd1);
    chk({tag, "_data0"}, 32'(data), 32'(exp_data));
    chk({tag, "_cmd0"}, 32'(cmd[7:1]), 32'(exp_cmd[7:1]));
    tick();
    chk({tag, "_data1"}, 32'(data), 32'(exp_data));
    chk({tag, "_cmd1"}, 32'(cmd[7:1]), 32'(exp_cmd[7:1]));
    tick();
    chk({tag, "_gap"}, 32'({cmd[7:1], data}), 32'd0);
  endtask

  task automatic push_kb(input logic [7:0] tok);
    int w = 0;
    kb_valid = 1'b1;
    kb_tok   = tok;
    while (!kb_ready && w < 40) begin
      tick();
      w++;
    end
    chk("kb_push_ready", 32'(kb_ready), 32'd1);
    tick();
    kb_valid = 1'b0;
  endtask

  task automatic push_ev(input logic [7:0] tok);
    int w = 0;
    ev_valid = 1'b1;
    ev_tok   = tok;
    while (!ev_ready && w < 40) begin
      tick();
      w++;
    end
    chk("ev_push_ready", 32'(ev_ready), 32'd1);
    tick();
    ev_valid = 1'b0;
  endtask

  initial begin
    reset     = 1'b0;
    kb_valid  = 1'b0;
    kb_tok    = 8'd0;
    ev_valid  = 1'b0;
    ev_tok    = 8'd0;
    ev_active = 1'b0;

    // Reset state
    repeat (3) tick();
    chk("rst_cmd", 32'(cmd), 32'd0);
    chk("rst_data", 32'(data), 32'd0);
    chk("rst_dropped", 32'(dropped), 32'd0);
    chk("rst_kb_ready", 32'(kb_ready), 32'd0);
    chk("rst_ev_ready", 32'(ev_ready), 32'd0);
    reset = 1'b1;
    tick();
    chk("rel_kb_ready", 32'(kb_ready), 32'd1);
    chk("rel_ev_ready", 32'(ev_ready), 32'd1);
    repeat (2) tick();

    // Single character: exact latency and slot/gap shape
    push_kb(8'd5);
    for (int i = 0; i < 5; i++) begin
      if (i > 0) tick();
      chk("c1_data", 32'(data), 32'(exp_c1[i]));
      chk("c1_cmd", 32'(cmd), 32'd0);
    end
    repeat (2) tick();

    // Round-robin, evaluator wins first tie
    kb_valid = 1'b1; kb_tok = 8'd1; ev_valid = 1'b1; ev_tok = 8'd27;
    tick();
    kb_tok = 8'd2; ev_tok = 8'd28;
    tick();
    kb_valid = 1'b0; ev_valid = 1'b0;
    expect_issue("rr0", 8'h00, 6'd27);
    expect_issue("rr1", 8'h00, 6'd1);
    expect_issue("rr2", 8'h00, 6'd28);
    expect_issue("rr3", 8'h00, 6'd2);
    repeat (4) tick();

    // Busy gating: head 3 blocks 67 while evaluator active
    ev_active = 1'b1;
    tick();
    push_kb(8'd3);
    push_kb(8'd67);
    for (int i = 0; i < 8; i++) begin
      tick();
      chk("gate_hold", 32'({cmd, data}), 32'({8'h01, 6'd0}));
    end
    chk("gate_kb_ready", 32'(kb_ready), 32'd1);
    ev_active = 1'b0;
    tick();
    chk("gate_d3_data0", 32'(data), 32'd3);
    chk("gate_d3_cmd0", 32'(cmd), 32'd0);
    tick();
    chk("gate_d3_data1", 32'(data), 32'd3);
    tick();
    chk("gate_d3_gap", 32'(data), 32'd0);
    expect_issue("pgup", 8'h02, 6'd0);
    chk("pgup_busy_low", 32'(cmd[0]), 32'd0);
    repeat (4) tick();

    // Full FIFO with output stalled by busy gating
    ev_active = 1'b1;
    tick();
    kb_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      chk("fill_ready", 32'(kb_ready), 32'd1);
      kb_tok = 8'(11 + i);
      tick();
    end
    chk("full_ready", 32'(kb_ready), 32'd0);
    kb_tok = 8'd15;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("full_hold_ready", 32'(kb_ready), 32'd0);
      chk("full_hold_data", 32'(data), 32'd0);
    end
    ev_active = 1'b0;
    tick();
    chk("full_d11_data0", 32'(data), 32'd11);
    chk("full_ready_back", 32'(kb_ready), 32'd1);
    tick();
    kb_valid = 1'b0;
    chk("full_d11_data1", 32'(data), 32'd11);
    tick();
    chk("full_d11_gap", 32'(data), 32'd0);
    expect_issue("full12", 8'h00, 6'd12);
    expect_issue("full13", 8'h00, 6'd13);
    expect_issue("full14", 8'h00, 6'd14);
    expect_issue("full15", 8'h00, 6'd15);
    for (int i = 0; i < 8; i++) begin
      tick();
      chk("full_no_extra", 32'({cmd, data}), 32'd0);
    end

    // Invalid token dropped, then breakline
    push_ev(8'd64);
    chk("inv_drop_early", 32'(dropped), 32'd0);
    push_ev(8'd66);
    chk("inv_drop_pulse", 32'(dropped), 32'd1);
    chk("inv_no_issue", 32'(cmd), 32'h01);
    chk("inv_no_data", 32'(data), 32'd0);
    tick();
    chk("inv_drop_end", 32'(dropped), 32'd0);
    chk("brk_cmd0", 32'(cmd), 32'h11);
    tick();
    chk("brk_cmd1", 32'(cmd), 32'h11);
    chk("brk_drop1", 32'(dropped), 32'd0);
    tick();
    chk("brk_gap0", 32'(cmd), 32'h01);
    tick();
    chk("brk_gap1", 32'(cmd), 32'h00);
    repeat (4) tick();

    // Mid-token reset with both FIFOs holding entries
    push_kb(8'd10);
    tick();
    chk("mr_issue", 32'(data), 32'd10);
    kb_valid = 1'b1; kb_tok = 8'd21; ev_valid = 1'b1; ev_tok = 8'd31;
    tick();
    kb_valid = 1'b0; ev_valid = 1'b0;
    reset = 1'b0;
    tick();
    chk("mr_cmd", 32'(cmd), 32'd0);
    chk("mr_data", 32'(data), 32'd0);
    chk("mr_kb_ready", 32'(kb_ready), 32'd0);
    chk("mr_ev_ready", 32'(ev_ready), 32'd0);
    reset = 1'b1;
    tick();
    chk("mr_rel_kb_ready", 32'(kb_ready), 32'd1);
    chk("mr_rel_ev_ready", 32'(ev_ready), 32'd1);
    for (int i = 0; i < 12; i++) begin
      tick();
      chk("mr_quiet", 32'({cmd, data}), 32'd0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
